dds_core: RTL and testbench
===========================

DDS_CORE -- requirements
Module: dds_core

Interface
REQ-001 Parameter: none; LUT fixed at 65536 x 16-bit signed two's-complement words.
REQ-002 clk  in  1  rising-edge clock; only clock domain.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 en  in  1  1 = phase accumulator and sample pipeline advance; 0 = all pipeline registers hold.
REQ-005 FreqCntrl  in  32  unsigned phase increment per enabled cycle.
REQ-006 PhaseCntrlA  in  32  channel A phase offset; bits [23:0] used (full turn = 2^24), bits [31:24] ignored.
REQ-007 PhaseCntrlB  in  32  channel B phase offset; same format as A.
REQ-008 AmplCntrlA  in  16 signed  channel A gain, Q1.15.
REQ-009 AmplCntrlB  in  16 signed  channel B gain, Q1.15.
REQ-010 DataPathSelect  in  1  1 = LUT sine path; 0 = direct-value path.
REQ-011 DirectValue  in  32  direct path data: [15:0] to A, [31:16] to B.
REQ-012 LUTWe  in  1  LUT write strobe, active-high, one word per clk while high.
REQ-013 LUTAddress  in  32  LUT write address; bits [15:0] used.
REQ-014 LUTData  in  32  LUT write data; bits [15:0] used.
REQ-015 SampleOutA  out  16 signed  channel A sample, registered.
REQ-016 SampleOutB  out  16 signed  channel B sample, registered.

Function
REQ-017 Phase accumulator acc[31:0]: when en=1, acc <= acc + FreqCntrl each clk, modulo 2^32 (silent wrap).
REQ-018 Stage 1 (en=1): addrX <= (acc + {PhaseCntrlX[23:0], 8'h00})[31:16], modulo 2^32, X = A, B.
REQ-019 Stage 2 (en=1): sampleX <= LUT[addrX]; synchronous read, two independent read ports.
REQ-020 Stage 3 (en=1): prodX <= sampleX * AmplCntrlX, full 32-bit signed product.
REQ-021 Stage 4 (en=1): SampleOutX <= DataPathSelect ? sat16(prodX >>> 15) : DirectValue slice.
REQ-022 sat16: clamp to [-32768, +32767]; only case reached is -32768 * -32768, giving +32767.
REQ-023 Arithmetic shift truncates toward minus infinity; no rounding.
REQ-024 Sine-path latency: acc value to SampleOut = 4 enabled clocks after acc update.
REQ-025 Direct path: DirectValue registered once at stage 4, so 1 enabled clock of latency.
REQ-026 DataPathSelect, AmplCntrl, PhaseCntrl, FreqCntrl are sampled live each clk; changes take effect without flushing the pipeline.
REQ-027 LUT write: on clk with LUTWe=1, LUT[LUTAddress[15:0]] <= LUTData[15:0].
REQ-028 LUT writes are independent of en and rst_n.
REQ-029 Same-cycle write and read at the same address: the read returns the old word.
REQ-030 en=0: acc, addr, sample, prod and both outputs hold their values; LUT writes still occur.

Reset
REQ-031 rst_n=0 at a clk edge: acc, addrA/B, sampleA/B, prodA/B, SampleOutA, SampleOutB <= 0.
REQ-032 Reset has priority over en.
REQ-033 LUT contents are not reset and are preserved across reset.
REQ-034 Reset asserted mid-operation clears the pipeline at that edge.
REQ-035 After release, outputs are 0 until fresh data propagates.

Verification
REQ-036 Reset: rst_n=0 for 2 clks with arbitrary inputs -> SampleOutA = SampleOutB = 0 on the next edge.
REQ-037 Ramp LUT: load LUT[i] = i; set FreqCntrl = 0x00010000, Phase = 0, Ampl = 0x4000, DataPathSelect = 1, en = 1 -> SampleOutA steps through i>>1, +1 address per clk, 4-clk latency from acc.
REQ-038 Phase offset: same LUT setup with PhaseCntrlB = 0x800000 -> addrB = addrA + 0x8000 (180 deg); SampleOutB = ((addrA + 0x8000) mod 65536 as signed) >>> 1.
REQ-039 Saturation: LUT[0] = 0x8000, FreqCntrl = 0, AmplCntrlA = 0x8000 -> SampleOutA = 0x7FFF.
REQ-040 Direct path and enable: DataPathSelect = 0, DirectValue = 0x1234ABCD -> next clk A = 0xABCD, B = 0x1234; with en = 0, changing DirectValue leaves outputs unchanged.
REQ-041 Wrap: acc = 0xFFFF0000, FreqCntrl = 0x00020000 -> next acc = 0x00010000; LUT address wraps 0xFFFF -> 0x0001.

Source files
------------

// File: rtl/dds_core.sv
// Two-channel direct digital synthesiser: a shared 32-bit phase accumulator feeds
// a 4-stage sine pipeline (offset, LUT read, gain, saturate) with a direct-value bypass.
module dds_core (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [31:0]        FreqCntrl,
    input  logic [31:0]        PhaseCntrlA,
    input  logic [31:0]        PhaseCntrlB,
    input  logic signed [15:0] AmplCntrlA,
    input  logic signed [15:0] AmplCntrlB,
    input  logic               DataPathSelect,
    input  logic [31:0]        DirectValue,
    input  logic               LUTWe,
    input  logic [31:0]        LUTAddress,
    input  logic [31:0]        LUTData,
    output logic signed [15:0] SampleOutA,
    output logic signed [15:0] SampleOutB
);

    // Product is Q2.30 after a Q1.15 x Q1.15 multiply; only -1 * -1 can overflow.
    function automatic logic signed [15:0] sat16(input logic signed [31:0] prod);
        logic signed [31:0] shifted;
        shifted = prod >>> 15;
        if (shifted > 32'sd32767)
            sat16 = 16'sh7FFF;
        else if (shifted < -32'sd32768)
            sat16 = 16'sh8000;
        else
            sat16 = shifted[15:0];
    endfunction

    logic [15:0]        lut_mem [0:65535];

    logic [31:0]        acc_q, acc_d;
    logic [31:0]        phase_a, phase_b;
    logic [15:0]        addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic signed [15:0] smp_a_q, smp_b_q;
    logic signed [31:0] prod_a_q, prod_a_d, prod_b_q, prod_b_d;
    logic signed [15:0] out_a_q, out_a_d, out_b_q, out_b_d;

    // Upper bits of the phase, address and data words are don't-care by design.
    logic unused_bits;
    assign unused_bits = ^{PhaseCntrlA[31:24], PhaseCntrlB[31:24],
                           LUTAddress[31:16], LUTData[31:16]};

    always_comb begin
        acc_d    = acc_q + FreqCntrl;
        phase_a  = acc_q + {PhaseCntrlA[23:0], 8'h00};
        phase_b  = acc_q + {PhaseCntrlB[23:0], 8'h00};
        addr_a_d = phase_a[31:16];
        addr_b_d = phase_b[31:16];
        prod_a_d = smp_a_q * AmplCntrlA;
        prod_b_d = smp_b_q * AmplCntrlB;
        out_a_d  = DataPathSelect ? sat16(prod_a_q) : DirectValue[15:0];
        out_b_d  = DataPathSelect ? sat16(prod_b_q) : DirectValue[31:16];
    end

    // NOTE: non-blocking writes here mean a same-edge read of the written address sees the old word.
    // NOTE: the table is deliberately left out of reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (LUTWe)
            lut_mem[LUTAddress[15:0]] <= LUTData[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            smp_a_q  <= '0;
            smp_b_q  <= '0;
            prod_a_q <= '0;
            prod_b_q <= '0;
            out_a_q  <= '0;
            out_b_q  <= '0;
        end else if (en) begin
            acc_q    <= acc_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            smp_a_q  <= $signed(lut_mem[addr_a_q]);
            smp_b_q  <= $signed(lut_mem[addr_b_q]);
            prod_a_q <= prod_a_d;
            prod_b_q <= prod_b_d;
            out_a_q  <= out_a_d;
            out_b_q  <= out_b_d;
        end
    end

    assign SampleOutA = out_a_q;
    assign SampleOutB = out_b_q;

endmodule

// File: tb/tb_dds_core.sv
// Scoreboard bench for dds_core: a bench-side accumulator and LUT copy predict each
// output sample four enabled clocks ahead; directed tasks cover bypass, hold and collisions.
module tb_dds_core;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic [31:0]        FreqCntrl;
    logic [31:0]        PhaseCntrlA;
    logic [31:0]        PhaseCntrlB;
    logic signed [15:0] AmplCntrlA;
    logic signed [15:0] AmplCntrlB;
    logic               DataPathSelect;
    logic [31:0]        DirectValue;
    logic               LUTWe;
    logic [31:0]        LUTAddress;
    logic [31:0]        LUTData;
    logic signed [15:0] SampleOutA;
    logic signed [15:0] SampleOutB;

    dds_core dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .FreqCntrl      (FreqCntrl),
        .PhaseCntrlA    (PhaseCntrlA),
        .PhaseCntrlB    (PhaseCntrlB),
        .AmplCntrlA     (AmplCntrlA),
        .AmplCntrlB     (AmplCntrlB),
        .DataPathSelect (DataPathSelect),
        .DirectValue    (DirectValue),
        .LUTWe          (LUTWe),
        .LUTAddress     (LUTAddress),
        .LUTData        (LUTData),
        .SampleOutA     (SampleOutA),
        .SampleOutB     (SampleOutB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: table copy, accumulator and expected-sample queues.
    logic [15:0] lut_m [0:65535];
    logic [31:0] acc_m;
    int          n_en;
    logic [15:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];
    logic [15:0] last_a, last_b;
    logic        have_last;

    function automatic logic [15:0] model_out(input logic [31:0] acc,
                                              input logic [31:0] ph,
                                              input logic signed [15:0] amp);
        logic [31:0]        a;
        logic signed [15:0] s;
        longint             p;
        longint             r;
        a = acc + {ph[23:0], 8'h00};
        s = $signed(lut_m[a[31:16]]);
        p = longint'(s) * longint'(amp);
        r = p >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_write(input logic [15:0] addr, input logic [15:0] data);
        LUTWe      = 1'b1;
        LUTAddress = {$urandom_range(0, 65535), addr};
        LUTData    = {$urandom_range(0, 65535), data};
        lut_m[addr] = data;
        tick();
        LUTWe = 1'b0;
    endtask

    task automatic model_reset();
        acc_m = '0;
        n_en  = 0;
        exp_a_q.delete();
        exp_b_q.delete();
        have_last = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n          = 1'b0;
        en             = 1'b1;
        FreqCntrl      = $urandom;
        PhaseCntrlA    = $urandom;
        PhaseCntrlB    = $urandom;
        AmplCntrlA     = 16'($urandom);
        AmplCntrlB     = 16'($urandom);
        DataPathSelect = 1'($urandom_range(0, 1));
        DirectValue    = $urandom;
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock of scoreboard-checked operation with the currently driven controls.
    task automatic sb_step(input logic en_v);
        logic [15:0] ea, eb;
        en = en_v;
        if (en_v) begin
            exp_a_q.push_back(model_out(acc_m, PhaseCntrlA, AmplCntrlA));
            exp_b_q.push_back(model_out(acc_m, PhaseCntrlB, AmplCntrlB));
            acc_m = acc_m + FreqCntrl;
            n_en++;
        end
        tick();
        if (en_v && n_en >= 4) begin
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            last_a    = ea;
            last_b    = eb;
            have_last = 1'b1;
            n_checks += 2;
            if (SampleOutA !== ea) begin
                n_fail++;
                $display("FAIL sine_a: got %h expected %h (enabled edge %0d)", SampleOutA, ea, n_en);
            end
            if (SampleOutB !== eb) begin
                n_fail++;
                $display("FAIL sine_b: got %h expected %h (enabled edge %0d)", SampleOutB, eb, n_en);
            end
        end else if (!en_v && have_last) begin
            n_checks += 2;
            if (SampleOutA !== last_a) begin
                n_fail++;
                $display("FAIL hold_a: got %h expected %h", SampleOutA, last_a);
            end
            if (SampleOutB !== last_b) begin
                n_fail++;
                $display("FAIL hold_b: got %h expected %h", SampleOutB, last_b);
            end
        end
    endtask

    task automatic sine_setup(input logic [31:0] freq, input logic [31:0] pha,
                              input logic [31:0] phb, input logic [15:0] amp_a,
                              input logic [15:0] amp_b);
        FreqCntrl      = freq;
        PhaseCntrlA    = pha;
        PhaseCntrlB    = phb;
        AmplCntrlA     = amp_a;
        AmplCntrlB     = amp_b;
        DataPathSelect = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            FreqCntrl      = $urandom;
            DirectValue    = $urandom;
            DataPathSelect = 1'($urandom_range(0, 1));
            tick();
            n_checks += 2;
            if (SampleOutA !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_a: got %h expected 0000", SampleOutA);
            end
            if (SampleOutB !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_b: got %h expected 0000", SampleOutB);
            end
        end
    endtask

    task automatic load_ramp();
        en = 1'b0;
        for (int i = 0; i < 64; i++) lut_write(16'(i), 16'(i));
        for (int i = 0; i < 64; i++) lut_write(16'(32'h8000 + i), 16'(32'h8000 + i));
        for (int i = 0; i < 16; i++) lut_write(16'(32'hFFF0 + i), 16'(32'hFFF0 + i));
    endtask

    task automatic test_ramp();
        do_reset(2);
        sine_setup(32'h0001_0000, 32'h0, 32'h0, 16'h4000, 16'h4000);
        for (int i = 0; i < 40; i++) sb_step(1'b1);
    endtask

    task automatic test_phase_offset();
        do_reset(2);
        sine_setup(32'h0001_0000, 32'h0, 32'h0080_0000, 16'h4000, 16'h4000);
        for (int i = 0; i < 8; i++) sb_step(1'b1);
        for (int i = 0; i < 30; i++) sb_step(logic'($urandom_range(0, 3) != 0));
    endtask

    task automatic test_wrap();
        en = 1'b0;
        lut_write(16'hFFFF, 16'h1234);
        lut_write(16'h0001, 16'h4321);
        do_reset(1);
        sine_setup(32'hFFFF_0000, 32'h0, 32'h0, 16'h4000, 16'h7FFF);
        sb_step(1'b1);
        FreqCntrl = 32'h0002_0000;
        for (int i = 0; i < 8; i++) sb_step(1'b1);
    endtask

    task automatic test_direct_enable();
        do_reset(1);
        DataPathSelect = 1'b0;
        DirectValue    = 32'h1234_ABCD;
        en             = 1'b1;
        tick();
        n_checks += 2;
        if (SampleOutA !== 16'hABCD) begin
            n_fail++;
            $display("FAIL direct_a: got %h expected abcd", SampleOutA);
        end
        if (SampleOutB !== 16'h1234) begin
            n_fail++;
            $display("FAIL direct_b: got %h expected 1234", SampleOutB);
        end
        en          = 1'b0;
        DirectValue = 32'h55AA_33CC;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (SampleOutA !== 16'hABCD || SampleOutB !== 16'h1234) begin
                n_fail++;
                $display("FAIL direct_hold: got %h/%h expected abcd/1234", SampleOutA, SampleOutB);
            end
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (SampleOutA !== 16'h33CC || SampleOutB !== 16'h55AA) begin
            n_fail++;
            $display("FAIL direct_resume: got %h/%h expected 33cc/55aa", SampleOutA, SampleOutB);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (SampleOutA !== 16'h0000 || SampleOutB !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset: got %h/%h expected 0000/0000", SampleOutA, SampleOutB);
        end
        model_reset();
    endtask

    task automatic test_lut_collision();
        do_reset(1);
        en = 1'b0;
        lut_write(16'h0010, 16'h0100);
        sine_setup(32'h0, 32'h0000_1000, 32'h0000_1000, 16'h4000, 16'h4000);
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (SampleOutA !== 16'h0080) begin
            n_fail++;
            $display("FAIL lut_written_while_idle: got %h expected 0080", SampleOutA);
        end
        lut_write(16'h0010, 16'h0200);
        tick();
        tick();
        n_checks++;
        if (SampleOutA !== 16'h0080) begin
            n_fail++;
            $display("FAIL collision_old_word: got %h expected 0080", SampleOutA);
        end
        tick();
        n_checks++;
        if (SampleOutA !== 16'h0100) begin
            n_fail++;
            $display("FAIL collision_new_word: got %h expected 0100", SampleOutA);
        end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        en    = 1'b0;
        lut_write(16'h0000, 16'h8000);
        do_reset(2);
        sine_setup(32'h0, 32'h0, 32'h0, 16'h8000, 16'h4000);
        for (int i = 0; i < 8; i++) sb_step(1'b1);
        n_checks++;
        if (SampleOutA !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL saturate_a: got %h expected 7fff", SampleOutA);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        en             = 1'b0;
        FreqCntrl      = '0;
        PhaseCntrlA    = '0;
        PhaseCntrlB    = '0;
        AmplCntrlA     = '0;
        AmplCntrlB     = '0;
        DataPathSelect = 1'b0;
        DirectValue    = '0;
        LUTWe          = 1'b0;
        LUTAddress     = '0;
        LUTData        = '0;
        model_reset();
        #2;

        test_reset();
        load_ramp();
        test_ramp();
        test_phase_offset();
        test_wrap();
        test_direct_enable();
        test_lut_collision();
        test_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
